store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
//   Circular FIFO holding bufferable, non-cachable stores (and stores that missed the cache) pushed by the store-unit cache controller.
//   Entries drain in order to the memory interface with a request/acknowledge handshake, so the store unit retires without waiting on memory.
//   Also flags loads whose word address matches a pending entry, so the load unit stalls until the conflict drains.
// PARAMETERS
//   BUFFER_DEPTH  4   number of entries; power of two, >= 2
//   ADDR_WIDTH    32  full byte address width
//   DATA_WIDTH    32  store data width (one word)
// PORTS
//   clk_i               in   1           clock
//   rst_n_i             in   1           reset, active low
//   push_data_i         in   1           push request from cache controller
//   data_i              in   DATA_WIDTH  store data, right-aligned (byte/half in LSBs)
//   address_i           in   ADDR_WIDTH  full byte address of store
//   operation_width_i   in   2           mem_op_width_t: BYTE / HALF_WORD / WORD
//   full_o              out  1           no free entry
//   empty_o             out  1           no valid entry
//   mem_request_o       out  1           head entry presented to memory
//   mem_address_o       out  ADDR_WIDTH  head entry address
//   mem_data_o          out  DATA_WIDTH  head entry data
//   mem_width_o         out  2           head entry width
//   mem_acknowledge_i   in   1           memory accepted head entry
//   ldu_address_i       in   ADDR_WIDTH  load address to check
//   ldu_conflict_o      out  1           load word address matches a pending entry
// BEHAVIOUR
//   - Clocking: single clock clk_i. Reset is synchronous, active-low on rst_n_i; all state updates on posedge clk_i.
//   - Reset: pointers = 0, count = 0, all valid bits = 0, FSM = IDLE.
//     Outputs after reset: full_o=0, empty_o=1, mem_request_o=0, ldu_conflict_o=0.
//     Entry storage is reset to 0, so mem_address_o/mem_data_o/mem_width_o read 0.
//   - Pointers: head/tail use log2(BUFFER_DEPTH) bits plus one wrap bit.
//     empty = (head == tail); full = index equal and wrap bits differ.
//     Wrap from BUFFER_DEPTH-1 to 0 flips the wrap bit.
//   - Push: on an edge with push_data_i=1 and full_o=0, the entry is written at tail and tail++.
//     A push while full_o=1 is ignored, even if a pop happens in the same cycle.
//     full_o/empty_o are registered-state based; a pushed entry is visible from the next cycle.
//   - Drain FSM, two states:
//     IDLE:  mem_request_o=0. If !empty_o -> WRITE.
//     WRITE: mem_request_o=1; mem_* = head entry.
//            If mem_acknowledge_i: pop (valid[head]=0, head++).
//              Stay in WRITE if an entry remains after the pop, counting a same-cycle push; otherwise -> IDLE.
//            If no ack: hold WRITE, keeping mem_* stable.
//   - Latency: push accepted at edge N -> mem_request_o high after edge N+1 (one IDLE cycle), when the buffer was previously empty.
//     Back-to-back entries: after the ack edge the next head is presented the following cycle with no bubble.
//   - Ack may arrive in the same cycle mem_request_o rises. mem_acknowledge_i is ignored in IDLE.
//   - Simultaneous push and pop when not full: both occur and the count is unchanged.
//   - Conflict check (combinational): ldu_conflict_o=1 iff some entry has valid=1 and address[ADDR_WIDTH-1:2] == ldu_address_i[ADDR_WIDTH-1:2].
//     Width is ignored, which is conservative.
//     The head entry counts until its ack edge. An entry pushed this cycle does not count until the next cycle.
//   - Reset mid-operation: all pending entries are discarded and mem_request_o drops in the cycle after the reset edge.
//   - No reordering and no merging; memory sees stores in push order.
// TESTING
//   1. Reset, then push one WORD to 0x0000_1000 data 0xDEADBEEF with ack held low
//      -> empty_o=0, mem_request_o=1 two cycles after the push, mem_width_o=WORD.
//      Raise ack -> empty_o=1, mem_request_o=0 the next cycle.
//   2. Push 4 entries, no ack -> full_o=1.
//      A 5th push (addr 0x50) is dropped; ack 4 times -> memory receives the original 4 in order; 0x50 never appears.
//   3. Buffer holds 2 entries, ack held high continuously
//      -> mem_request_o stays high, two accepted transfers on consecutive cycles, then IDLE.
//   4. Full buffer, push and ack in the same cycle -> push dropped, count goes 4 -> 3, full_o=0.
//   5. Pending BYTE store at 0x0000_2003; ldu_address_i=0x0000_2000 -> ldu_conflict_o=1.
//      ldu_address_i=0x0000_2004 -> 0. After the ack edge -> 0.
//   6. Three entries pending in WRITE; assert rst_n_i=0 for one cycle
//      -> empty_o=1, mem_request_o=0, and later pushes drain starting from index 0.

Source files
------------

// File: rtl/store_buffer_if.sv
// Store-buffer port bundle: cache-controller push side, memory drain side, load-unit conflict probe.
interface store_buffer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  push_data_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic [ADDR_WIDTH-1:0] address_i;
  logic [1:0]            operation_width_i;
  logic                  full_o;
  logic                  empty_o;
  logic                  mem_request_o;
  logic [ADDR_WIDTH-1:0] mem_address_o;
  logic [DATA_WIDTH-1:0] mem_data_o;
  logic [1:0]            mem_width_o;
  logic                  mem_acknowledge_i;
  logic [ADDR_WIDTH-1:0] ldu_address_i;
  logic                  ldu_conflict_o;

  modport master (
    output push_data_i, data_i, address_i, operation_width_i, mem_acknowledge_i, ldu_address_i,
    input  full_o, empty_o, mem_request_o, mem_address_o, mem_data_o, mem_width_o, ldu_conflict_o
  );

  modport slave (
    input  push_data_i, data_i, address_i, operation_width_i, mem_acknowledge_i, ldu_address_i,
    output full_o, empty_o, mem_request_o, mem_address_o, mem_data_o, mem_width_o, ldu_conflict_o
  );
endinterface

// File: rtl/store_buffer.sv
// In-order store buffer: circular FIFO drained to memory by a two-state req/ack FSM,
// with a combinational word-address conflict check for the load unit.
module store_buffer #(
  parameter int BUFFER_DEPTH = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32
) (
  input logic           clk_i,
  input logic           rst_n_i,
  store_buffer_if.slave sb
);
  localparam int IW = $clog2(BUFFER_DEPTH);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t                                   state;
  logic [IW:0]                              head, tail;
  logic [BUFFER_DEPTH-1:0]                  valid;
  logic [BUFFER_DEPTH-1:0][ADDR_WIDTH-1:0]  addr_q;
  logic [BUFFER_DEPTH-1:0][DATA_WIDTH-1:0]  data_q;
  logic [BUFFER_DEPTH-1:0][1:0]             width_q;
  logic [BUFFER_DEPTH-1:0]                  hit;

  logic          full, empty, push, pop;
  logic [IW:0]   remaining;
  logic [IW-1:0] head_idx, tail_idx;

  assign head_idx = head[IW-1:0];
  assign tail_idx = tail[IW-1:0];
  assign empty    = (head == tail);
  assign full     = (head_idx == tail_idx) && (head[IW] != tail[IW]);
  assign push     = sb.push_data_i && !full;
  assign pop      = (state == WRITE) && sb.mem_acknowledge_i;
  // Occupancy after this edge, counting a same-cycle push; pointer math wraps naturally.
  assign remaining = tail - head + (IW+1)'(push) - (IW+1)'(pop);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      head    <= '0;
      tail    <= '0;
      valid   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      width_q <= '0;
      state   <= IDLE;
    end else begin
      if (push) begin
        addr_q[tail_idx]  <= sb.address_i;
        data_q[tail_idx]  <= sb.data_i;
        width_q[tail_idx] <= sb.operation_width_i;
        valid[tail_idx]   <= 1'b1;
        tail              <= tail + (IW+1)'(1);
      end
      // A pop never collides with the push slot: push needs !full, pop needs non-empty.
      if (pop) begin
        valid[head_idx] <= 1'b0;
        head            <= head + (IW+1)'(1);
      end
      case (state)
        IDLE:    if (!empty) state <= WRITE;
        WRITE:   if (pop && remaining == '0) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < BUFFER_DEPTH; g++) begin : g_hit
    assign hit[g] = valid[g] && (addr_q[g][ADDR_WIDTH-1:2] == sb.ldu_address_i[ADDR_WIDTH-1:2]);
  end

  assign sb.ldu_conflict_o = |hit;
  assign sb.full_o         = full;
  assign sb.empty_o        = empty;
  assign sb.mem_request_o  = (state == WRITE);
  assign sb.mem_address_o  = addr_q[head_idx];
  assign sb.mem_data_o     = data_q[head_idx];
  assign sb.mem_width_o    = width_q[head_idx];
endmodule

// File: tb/tb_store_buffer.sv
// Randomized + directed bench for store_buffer; a queue-based reference model feeds a scoreboard monitor.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam logic [1:0] BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  store_buffer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) sb();

  store_buffer #(.BUFFER_DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .sb      (sb)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [1:0]    w;
  } st_t;

  st_t q[$];          // pending stores, oldest first
  bit  req_m  = 1'b0; // model: head is being offered to memory
  bit  live   = 1'b0;
  int  n_cmp  = 0;
  int  n_bad  = 0;
  int  n_xfer = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare outputs against model at negedge, then advance the model
  // with the inputs that the next posedge will sample.
  initial begin : monitor
    int  old;
    bit  pop, conf;
    st_t e;
    forever begin
      @(negedge clk);
      if (live) begin
        chk("empty", 64'(sb.empty_o), 64'(q.size() == 0));
        chk("full", 64'(sb.full_o), 64'(q.size() == DEPTH));
        chk("mem_request", 64'(sb.mem_request_o), 64'(req_m));
        conf = 1'b0;
        foreach (q[i]) if (q[i].a[AW-1:2] == sb.ldu_address_i[AW-1:2]) conf = 1'b1;
        chk("ldu_conflict", 64'(sb.ldu_conflict_o), 64'(conf));
        if (req_m && q.size() > 0) begin
          chk("mem_address", 64'(sb.mem_address_o), 64'(q[0].a));
          chk("mem_data", 64'(sb.mem_data_o), 64'(q[0].d));
          chk("mem_width", 64'(sb.mem_width_o), 64'(q[0].w));
        end
      end
      if (!rst_n) begin
        q.delete();
        req_m = 1'b0;
        live  = 1'b1;
      end else if (live) begin
        old = q.size();
        pop = req_m && sb.mem_acknowledge_i;
        if (pop) begin
          n_xfer++;
          void'(q.pop_front());
        end
        if (sb.push_data_i && old < DEPTH) begin
          e.a = sb.address_i;
          e.d = sb.data_i;
          e.w = sb.operation_width_i;
          q.push_back(e);
        end
        req_m = req_m ? (q.size() > 0) : (old > 0);
      end
    end
  end

  task automatic drive(bit p, logic [AW-1:0] a, logic [DW-1:0] d, logic [1:0] w,
                       bit ack, logic [AW-1:0] ldu);
    sb.push_data_i       = p;
    sb.address_i         = a;
    sb.data_i            = d;
    sb.operation_width_i = w;
    sb.mem_acknowledge_i = ack;
    sb.ldu_address_i     = ldu;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n, bit ack);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, BYTE, ack, '0);
  endtask

  initial begin : stim
    int x0;
    sb.push_data_i = 1'b0; sb.address_i = '0; sb.data_i = '0;
    sb.operation_width_i = BYTE; sb.mem_acknowledge_i = 1'b0; sb.ldu_address_i = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // single word store, ack held low then raised
    drive(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, WORD, 1'b0, '0);
    idle(3, 1'b0);
    chk("t1_width", 64'(sb.mem_width_o), 64'(WORD));
    idle(1, 1'b1);
    idle(2, 1'b0);

    // fill, overflow push dropped, drain in order
    for (int i = 1; i <= 4; i++) drive(1'b1, 32'(i * 16), 32'(32'hA0 + i), WORD, 1'b0, '0);
    chk("t2_full", 64'(sb.full_o), 64'd1);
    drive(1'b1, 32'h50, 32'h5555, WORD, 1'b0, '0);
    x0 = n_xfer;
    idle(4, 1'b1);
    idle(2, 1'b0);
    chk("t2_xfers", 64'(n_xfer - x0), 64'd4);
    chk("t2_empty", 64'(sb.empty_o), 64'd1);

    // two entries with ack held high
    drive(1'b1, 32'h300, 32'h1, HALF, 1'b0, '0);
    drive(1'b1, 32'h304, 32'h2, WORD, 1'b0, '0);
    idle(4, 1'b1);

    // full buffer, push and ack together
    for (int i = 0; i < 4; i++) drive(1'b1, 32'(32'h400 + i * 4), 32'(i), WORD, 1'b0, '0);
    idle(2, 1'b0);
    drive(1'b1, 32'h999, 32'h99, WORD, 1'b1, '0);
    chk("t4_full_after", 64'(sb.full_o), 64'd0);
    idle(1, 1'b0);
    idle(5, 1'b1);

    // byte store conflict probe
    drive(1'b1, 32'h0000_2003, 32'h7F, BYTE, 1'b0, 32'h0000_2000);
    drive(1'b0, '0, '0, BYTE, 1'b0, 32'h0000_2000);
    chk("t5_conflict", 64'(sb.ldu_conflict_o), 64'd1);
    drive(1'b0, '0, '0, BYTE, 1'b0, 32'h0000_2004);
    chk("t5_no_conflict", 64'(sb.ldu_conflict_o), 64'd0);
    drive(1'b0, '0, '0, BYTE, 1'b1, 32'h0000_2000);
    drive(1'b0, '0, '0, BYTE, 1'b0, 32'h0000_2000);
    chk("t5_after_ack", 64'(sb.ldu_conflict_o), 64'd0);

    // reset with pending entries, then resume
    for (int i = 0; i < 3; i++) drive(1'b1, 32'(32'h600 + i * 4), 32'(i + 7), WORD, 1'b0, '0);
    idle(2, 1'b0);
    rst_n = 1'b0;
    idle(1, 1'b0);
    rst_n = 1'b1;
    chk("t6_empty", 64'(sb.empty_o), 64'd1);
    chk("t6_req", 64'(sb.mem_request_o), 64'd0);
    drive(1'b1, 32'h700, 32'hBB, HALF, 1'b0, '0);
    drive(1'b1, 32'h704, 32'hCC, BYTE, 1'b0, '0);
    idle(4, 1'b1);

    // random traffic on a small address window so conflicts are frequent
    for (int i = 0; i < 600; i++)
      drive(($urandom_range(0, 9) < 6), 32'(32'h100 + $urandom_range(0, 15)), $urandom,
            2'($urandom_range(0, 2)), $urandom_range(0, 1) == 1,
            32'(32'h100 + $urandom_range(0, 15)));

    idle(10, 1'b1);
    chk("final_empty", 64'(sb.empty_o), 64'd1);
    idle(1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
